// File: rtl/lza_lzc_decoder.sv
// lza_lzc_decoder: two-stage pipelined leading-zero counter that turns an LZA indicator
// string plus its concurrent-correction bit into the normaliser shift amount.
module lza_lzc_decoder #(
    parameter int DATA_WIDTH  = 8,
    parameter int GROUP_WIDTH = 4,
    parameter int CNT_WIDTH   = $clog2(DATA_WIDTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] string_f,
    input  logic                  in_corr,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [CNT_WIDTH-1:0]  lz_count,
    output logic [CNT_WIDTH-1:0]  shift_amt,
    output logic                  all_zero
);
    localparam int N  = DATA_WIDTH / GROUP_WIDTH;
    localparam int LW = GROUP_WIDTH > 1 ? $clog2(GROUP_WIDTH) : 1;

    logic                 s1_valid_q, out_valid_q;
    logic [N-1:0]         nz_q, nz_d;
    logic [N-1:0][LW-1:0] lc_q, lc_d;
    logic                 corr_q;
    logic [CNT_WIDTH-1:0] lz_q, lz_d, sh_q, sh_d;
    logic                 az_q, az_d;
    logic [CNT_WIDTH:0]   sum;
    logic                 s2_load, in_fire;

    function automatic logic [LW-1:0] lzc_grp(input logic [GROUP_WIDTH-1:0] v);
        lzc_grp = '0;
        for (int i = 0; i < GROUP_WIDTH; i++)
            if (v[i]) lzc_grp = LW'(GROUP_WIDTH - 1 - i);
    endfunction

    assign s2_load   = !out_valid_q || out_ready;
    assign in_ready  = !s1_valid_q || s2_load;
    assign in_fire   = in_valid && in_ready;
    assign out_valid = out_valid_q;
    assign lz_count  = lz_q;
    assign shift_amt = sh_q;
    assign all_zero  = az_q;

    always_comb begin
        for (int g = 0; g < N; g++) begin
            nz_d[g] = |string_f[DATA_WIDTH-1-g*GROUP_WIDTH -: GROUP_WIDTH];
            lc_d[g] = lzc_grp(string_f[DATA_WIDTH-1-g*GROUP_WIDTH -: GROUP_WIDTH]);
        end
    end

    // Scan from the least-significant group up so the most-significant nonzero group wins.
    always_comb begin
        lz_d = CNT_WIDTH'(DATA_WIDTH);
        for (int g = N - 1; g >= 0; g--)
            if (nz_q[g]) lz_d = CNT_WIDTH'(g * GROUP_WIDTH) + CNT_WIDTH'(lc_q[g]);
        az_d = ~|nz_q;
        sum  = {1'b0, lz_d} + (CNT_WIDTH+1)'(corr_q);
        sh_d = sum > (CNT_WIDTH+1)'(DATA_WIDTH) ? CNT_WIDTH'(DATA_WIDTH) : sum[CNT_WIDTH-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            out_valid_q <= 1'b0;
            nz_q        <= '0;
            lc_q        <= '0;
            corr_q      <= 1'b0;
            lz_q        <= '0;
            sh_q        <= '0;
            az_q        <= 1'b0;
        end else begin
            if (in_fire) begin
                s1_valid_q <= 1'b1;
                nz_q       <= nz_d;
                lc_q       <= lc_d;
                corr_q     <= in_corr;
            end else if (s2_load) begin
                s1_valid_q <= 1'b0;
            end
            if (s2_load) begin
                out_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    lz_q <= lz_d;
                    sh_q <= sh_d;
                    az_q <= az_d;
                end
            end
        end
    end
endmodule

// File: tb/tb_lza_lzc_decoder.sv
// tb_lza_lzc_decoder: directed vectors with hand-computed counts for the 8-bit, 4-bit-group
// configuration, covering latency, streaming, backpressure and mid-stream reset.
module tb_lza_lzc_decoder;
    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] string_f;
    logic       in_corr;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] lz_count;
    logic [3:0] shift_amt;
    logic       all_zero;

    int errors = 0;
    int checks = 0;

    lza_lzc_decoder dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .string_f(string_f), .in_corr(in_corr), .out_valid(out_valid),
        .out_ready(out_ready), .lz_count(lz_count), .shift_amt(shift_amt),
        .all_zero(all_zero)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; string_f = 8'h00; in_corr = 1'b0; out_ready = 1'b1;
        cyc(); cyc();
        rst = 1'b0;
        #1;
        checks += 5;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
        if (lz_count !== 4'd0) begin errors++; $display("FAIL reset_lz got=%0d exp=0", lz_count); end
        if (shift_amt !== 4'd0) begin errors++; $display("FAIL reset_shift got=%0d exp=0", shift_amt); end
        if (all_zero !== 1'b0) begin errors++; $display("FAIL reset_all_zero got=%0b exp=0", all_zero); end
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
    endtask

    task automatic test_basic();
        logic [7:0] f  [9] = '{8'h16, 8'h16, 8'h80, 8'h01, 8'h00, 8'h00, 8'h20, 8'h08, 8'h07};
        logic       c  [9] = '{1'b0,  1'b1,  1'b1,  1'b1,  1'b1,  1'b0,  1'b0,  1'b1,  1'b0};
        logic [3:0] lz [9] = '{4'd3,  4'd3,  4'd0,  4'd7,  4'd8,  4'd8,  4'd2,  4'd4,  4'd5};
        logic [3:0] sh [9] = '{4'd3,  4'd4,  4'd1,  4'd8,  4'd8,  4'd8,  4'd2,  4'd5,  4'd5};
        logic       az [9] = '{1'b0,  1'b0,  1'b0,  1'b0,  1'b1,  1'b1,  1'b0,  1'b0,  1'b0};
        out_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            in_valid = 1'b1; string_f = f[i]; in_corr = c[i];
            cyc();
            in_valid = 1'b0; string_f = 8'hxx; in_corr = 1'bx;
            checks++;
            if (out_valid !== 1'b0) begin errors++; $display("FAIL basic%0d_early_valid got=%0b exp=0", i, out_valid); end
            cyc();
            checks += 4;
            if (out_valid !== 1'b1) begin errors++; $display("FAIL basic%0d_valid got=%0b exp=1", i, out_valid); end
            if (lz_count !== lz[i]) begin errors++; $display("FAIL basic%0d_lz f=%h got=%0d exp=%0d", i, f[i], lz_count, lz[i]); end
            if (shift_amt !== sh[i]) begin errors++; $display("FAIL basic%0d_shift f=%h got=%0d exp=%0d", i, f[i], shift_amt, sh[i]); end
            if (all_zero !== az[i]) begin errors++; $display("FAIL basic%0d_all_zero got=%0b exp=%0b", i, all_zero, az[i]); end
            cyc();
            checks++;
            if (out_valid !== 1'b0) begin errors++; $display("FAIL basic%0d_drain got=%0b exp=0", i, out_valid); end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] f  [3] = '{8'h80, 8'h10, 8'h03};
        logic [3:0] lz [3] = '{4'd0, 4'd3, 4'd6};
        out_ready = 1'b1; in_corr = 1'b0;
        for (int cy = 0; cy < 6; cy++) begin
            in_valid = cy < 3;
            string_f = cy < 3 ? f[cy] : 8'h00;
            #1;
            checks += 2;
            if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready cy=%0d got=%0b exp=1", cy, in_ready); end
            if (out_valid !== (cy >= 2 && cy <= 4)) begin
                errors++; $display("FAIL b2b_valid cy=%0d got=%0b exp=%0b", cy, out_valid, cy >= 2 && cy <= 4);
            end
            if (cy >= 2 && cy <= 4) begin
                checks++;
                if (lz_count !== lz[cy-2]) begin errors++; $display("FAIL b2b_lz cy=%0d got=%0d exp=%0d", cy, lz_count, lz[cy-2]); end
            end
            cyc();
        end
        in_valid = 1'b0;
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        in_valid = 1'b1; string_f = 8'h40; in_corr = 1'b0; #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_a got=%0b exp=1", in_ready); end
        cyc();
        string_f = 8'h04; in_corr = 1'b1; #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_b got=%0b exp=1", in_ready); end
        cyc();
        string_f = 8'h00; in_corr = 1'b0;
        for (int cy = 0; cy < 2; cy++) begin
            #1;
            checks += 5;
            if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_full cy=%0d got=%0b exp=0", cy, in_ready); end
            if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold_valid cy=%0d got=%0b exp=1", cy, out_valid); end
            if (lz_count !== 4'd1) begin errors++; $display("FAIL bp_hold_lz cy=%0d got=%0d exp=1", cy, lz_count); end
            if (shift_amt !== 4'd1) begin errors++; $display("FAIL bp_hold_shift cy=%0d got=%0d exp=1", cy, shift_amt); end
            if (all_zero !== 1'b0) begin errors++; $display("FAIL bp_hold_all_zero cy=%0d got=%0b exp=0", cy, all_zero); end
            cyc();
        end
        out_ready = 1'b1; #1;
        checks += 2;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready got=%0b exp=1", in_ready); end
        if (lz_count !== 4'd1) begin errors++; $display("FAIL bp_first_lz got=%0d exp=1", lz_count); end
        cyc();
        in_valid = 1'b0;
        checks += 3;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_second_valid got=%0b exp=1", out_valid); end
        if (lz_count !== 4'd5) begin errors++; $display("FAIL bp_second_lz got=%0d exp=5", lz_count); end
        if (shift_amt !== 4'd6) begin errors++; $display("FAIL bp_second_shift got=%0d exp=6", shift_amt); end
        cyc();
        checks += 4;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_third_valid got=%0b exp=1", out_valid); end
        if (lz_count !== 4'd8) begin errors++; $display("FAIL bp_third_lz got=%0d exp=8", lz_count); end
        if (shift_amt !== 4'd8) begin errors++; $display("FAIL bp_third_shift got=%0d exp=8", shift_amt); end
        if (all_zero !== 1'b1) begin errors++; $display("FAIL bp_third_all_zero got=%0b exp=1", all_zero); end
        cyc();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_no_dup got=%0b exp=0", out_valid); end
    endtask

    task automatic test_reset_midstream();
        out_ready = 1'b0; in_corr = 1'b1;
        in_valid = 1'b1; string_f = 8'h80; cyc();
        string_f = 8'h10; cyc();
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL mid_full got=%0b exp=0", in_ready); end
        rst = 1'b1; out_ready = 1'b1; string_f = 8'h01;
        cyc();
        rst = 1'b0; in_valid = 1'b0; #1;
        checks += 5;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_valid got=%0b exp=0", out_valid); end
        if (lz_count !== 4'd0) begin errors++; $display("FAIL mid_lz got=%0d exp=0", lz_count); end
        if (shift_amt !== 4'd0) begin errors++; $display("FAIL mid_shift got=%0d exp=0", shift_amt); end
        if (all_zero !== 1'b0) begin errors++; $display("FAIL mid_all_zero got=%0b exp=0", all_zero); end
        if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_in_ready got=%0b exp=1", in_ready); end
        for (int cy = 0; cy < 3; cy++) begin
            cyc();
            checks++;
            if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_stale cy=%0d got=%0b exp=0", cy, out_valid); end
        end
    endtask

    task automatic test_recovery();
        out_ready = 1'b1;
        in_valid = 1'b1; string_f = 8'h02; in_corr = 1'b1;
        cyc();
        in_valid = 1'b0;
        cyc();
        checks += 3;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL rec_valid got=%0b exp=1", out_valid); end
        if (lz_count !== 4'd6) begin errors++; $display("FAIL rec_lz got=%0d exp=6", lz_count); end
        if (shift_amt !== 4'd7) begin errors++; $display("FAIL rec_shift got=%0d exp=7", shift_amt); end
        cyc();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_backpressure();
        test_reset_midstream();
        test_recovery();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/lza_lzc_decoder.md
Name: lza_lzc_decoder

Overview:
- Consumer side of the LZA pre-encoder: takes the leading-one indicator string (string_f) plus the concurrent-correction bit.
- Produces the normalisation shift amount for the post-adder normaliser.
- Two-stage pipelined leading-zero counter with valid/ready handshake on both sides; sits between the pre-encoding/CC logic and the normalisation shifter.

Parameters:
- DATA_WIDTH, 8, width of string_f; must be a multiple of GROUP_WIDTH and ≥ GROUP_WIDTH.
- GROUP_WIDTH, 4, bits per stage-1 group for the partial leading-zero count.
- CNT_WIDTH, $clog2(DATA_WIDTH)+1, width of count outputs; must represent the value DATA_WIDTH.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  string_f/in_corr valid.
- in_ready  output  1  block accepts input this cycle.
- string_f  input  DATA_WIDTH  LZA indicator string; MSB is bit DATA_WIDTH-1.
- in_corr  input  1  concurrent-correction bit: anticipation is one position short.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- lz_count  output  CNT_WIDTH  raw leading-zero count of string_f.
- shift_amt  output  CNT_WIDTH  lz_count + corr, saturated at DATA_WIDTH.
- all_zero  output  1  string_f was all zeros.

Behaviour:
- Handshake:
  - Input transfer when in_valid && in_ready.
  - Output transfer when out_valid && out_ready.
  - Upstream may not withdraw or alter inputs while in_valid && !in_ready; the block must not depend on this.
- Pipeline:
  - s1 register and s2 (output) register, each with its own valid bit.
  - s2_load = !s2_valid || out_ready.
  - in_ready = !s1_valid || s2_load. Purely combinational from register state and out_ready; no combinational path from in_valid.
- Stage 1, on input transfer:
  - Split string_f into N = DATA_WIDTH/GROUP_WIDTH groups; group 0 is the most-significant.
  - Per group, register a nonzero flag and the local leading-zero count (0..GROUP_WIDTH-1; value don't-care when the flag is 0, but registered as 0).
  - Register in_corr. s1_valid <= 1.
  - When s2_load is true and there is no input transfer, s1_valid <= 0.
- Stage 2, when s2_load && s1_valid:
  - Find the first nonzero group k.
  - lz_count = k*GROUP_WIDTH + local_count[k].
  - If no group is nonzero: lz_count = DATA_WIDTH and all_zero = 1.
  - shift_amt = min(lz_count + corr, DATA_WIDTH).
  - out_valid <= 1.
  - When s2_load is true and s1_valid = 0: out_valid <= 0.
- Latency and throughput:
  - Exactly 2 cycles from input transfer to out_valid with no backpressure.
  - Sustains 1 result/cycle.
- Backpressure:
  - While out_valid && !out_ready, lz_count, shift_amt and all_zero hold stable. s1 holds if valid.
  - Up to 2 items may be buffered; in_ready = 0 only when both stages are full and out_ready = 0.
  - No item is dropped or duplicated.
- Simultaneous events: an output transfer and a new s1 entry in the same cycle is legal. Both stages advance together.
- Reset:
  - rst = 1 clears s1_valid and out_valid to 0.
  - lz_count, shift_amt, all_zero, s1 groups and s1 corr are cleared to 0.
  - in_ready = 1 in the first cycle after reset deasserts.
  - Reset mid-stream discards all in-flight items; rst dominates any handshake in the same cycle.
- Arithmetic: unsigned. The sum uses CNT_WIDTH+1 internal bits before saturation. lz_count never exceeds DATA_WIDTH.

Test Plan:
- DATA_WIDTH=8, out_ready=1:
  - string_f=8'b0001_0110, in_corr=0 → after 2 cycles lz_count=3, shift_amt=3, all_zero=0.
  - Same string_f with in_corr=1 → shift_amt=4.
- string_f=8'h80, corr=1 → lz_count=0, shift_amt=1.
- string_f=8'h01, corr=1 → lz_count=7, shift_amt=8.
- string_f=8'h00, corr=1 → lz_count=8, all_zero=1, shift_amt=8 (saturated).
- Back-to-back stream of f=8'h80, 8'h10, 8'h03 on cycles 0–2, out_ready=1 → out_valid on cycles 2–4 with lz_count 0, 3, 6; in_ready stays 1.
- Backpressure: send 3 items with out_ready=0 → first 2 accepted; in_ready=0 from the cycle both stages are full; outputs stable. Raise out_ready → items emerge in order, third accepted, no loss.
- Reset mid-operation: assert rst for 1 cycle with 2 items in flight → out_valid=0 and all outputs 0 the next cycle, in_ready=1; no stale result ever appears.
